// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//  Shared definitions for the generic pipeline stage register.
//  - pipe_state_e : occupancy states of the 2-entry skid variant.
//  - Per-stage payload structs so the old fixed fetch/decode/execute/memory/
//    writeback registers become pipe_stage_reg instances with
//    WIDTH = $bits(<struct>).
//  - Small state-decode helpers shared by the skid buffer.
// ---------------------------------------------------------------------------
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      TWO   = 2'd2
   } pipe_state_e;

   localparam int unsigned XLEN = 32;

   // fetch -> decode
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_decode_t;

   // writeback control bits, carried from decode onwards
   typedef struct packed {
      logic       reg_write;
      logic [4:0] rd;
      logic       mem_to_reg;
   } ctrl_w_t;

   // decode -> execute
   typedef struct packed {
      ctrl_w_t         ctrl_w;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_val;
      logic [XLEN-1:0] rs2_val;
      logic [XLEN-1:0] imm;
      logic [3:0]      alu_op;
   } decode_exec_t;

   // execute -> memory
   typedef struct packed {
      ctrl_w_t         ctrl_w;
      logic [XLEN-1:0] alu_res;
      logic [XLEN-1:0] store_val;
      logic            mem_read;
      logic            mem_write;
   } exec_mem_t;

   // memory -> writeback
   typedef struct packed {
      ctrl_w_t         ctrl_w;
      logic [XLEN-1:0] result;
   } mem_wb_t;

   // A state holds a payload for downstream unless it is EMPTY.
   function automatic logic state_has_data(input pipe_state_e s);
      return (s != EMPTY);
   endfunction

   // Only the TWO state refuses new payloads.
   function automatic logic state_can_accept(input pipe_state_e s);
      return (s != TWO);
   endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// ---------------------------------------------------------------------------
// pipe_skid_buf
//  Two-entry skid buffer: main register feeds data_o, skid register catches
//  the payload that arrives in the cycle downstream stalls. ready_o and
//  valid_o are registered alongside the state, so no combinational path
//  exists from ready_i to ready_o.
// Ports
//  clk_i    in   1      clock
//  rst_ni   in   1      synchronous active-low reset
//  flush_i  in   1      synchronous flush, empties the buffer
//  valid_i  in   1      upstream payload valid
//  ready_o  out  1      buffer can accept (state != TWO)
//  data_i   in   WIDTH  upstream payload
//  valid_o  out  1      main register holds a payload (state != EMPTY)
//  ready_i  in   1      downstream accepts
//  data_o   out  WIDTH  main register
// ---------------------------------------------------------------------------
module pipe_skid_buf
   import pipe_pkg::*;
#(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] data_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] data_o
);

   pipe_state_e      state_r;
   logic             valid_r;
   logic             ready_r;
   logic [WIDTH-1:0] main_r;
   logic [WIDTH-1:0] skid_r;

   logic             in_s;
   logic             out_s;

   assign in_s  = valid_i & ready_r;
   assign out_s = valid_r & ready_i;

   // Occupancy FSM; valid_r/ready_r are registered copies of the state decode.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_r <= EMPTY;
         valid_r <= 1'b0;
         ready_r <= 1'b1;
         main_r  <= RESET_VAL;
         skid_r  <= RESET_VAL;
      end else if (flush_i) begin
         // data registers keep their (now meaningless) contents
         state_r <= EMPTY;
         valid_r <= state_has_data(EMPTY);
         ready_r <= state_can_accept(EMPTY);
      end else begin
         case (state_r)
            EMPTY: begin
               if (in_s) begin
                  main_r  <= data_i;
                  state_r <= FULL;
                  valid_r <= state_has_data(FULL);
                  ready_r <= state_can_accept(FULL);
               end
            end
            FULL: begin
               if (in_s && out_s) begin
                  main_r <= data_i;
               end else if (in_s) begin
                  // downstream stalled: park the newcomer behind main
                  skid_r  <= data_i;
                  state_r <= TWO;
                  valid_r <= state_has_data(TWO);
                  ready_r <= state_can_accept(TWO);
               end else if (out_s) begin
                  state_r <= EMPTY;
                  valid_r <= state_has_data(EMPTY);
                  ready_r <= state_can_accept(EMPTY);
               end
            end
            TWO: begin
               if (out_s) begin
                  main_r  <= skid_r;
                  state_r <= FULL;
                  valid_r <= state_has_data(FULL);
                  ready_r <= state_can_accept(FULL);
               end
            end
            default: begin
               state_r <= EMPTY;
               valid_r <= 1'b0;
               ready_r <= 1'b1;
            end
         endcase
      end
   end

   assign ready_o = ready_r;
   assign valid_o = valid_r;
   assign data_o  = main_r;

endmodule

// File: rtl/pipe_stage_reg_chk.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg_chk
//  Protocol checker for the downstream side of pipe_stage_reg: while a payload
//  is stalled (valid_o & ~ready_i, no flush, not in reset) it must stay
//  valid and unchanged on the following cycle.
// Ports (all inputs)
//  clk_i, rst_ni, flush_i, valid_o, ready_i, data_o[WIDTH]
// ---------------------------------------------------------------------------
module pipe_stage_reg_chk #(
   parameter int unsigned WIDTH = 32
) (
   input logic             clk_i,
   input logic             rst_ni,
   input logic             flush_i,
   input logic             valid_o,
   input logic             ready_i,
   input logic [WIDTH-1:0] data_o
);

   a_stall_hold: assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      (valid_o && !ready_i && !flush_i) |=> (valid_o && $stable(data_o))
   ) else $error("pipe_stage_reg: stalled payload dropped or changed");

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//  Generic pipeline stage register with ready/valid handshake, synchronous
//  flush, optional 2-entry skid buffer and a saturating stall counter.
// Parameters
//  WIDTH      payload width
//  SKID       0: single register, ready_o = ready_i | ~valid_o
//             1: 2-entry skid buffer, ready_o from registered state only
//  RESET_VAL  reset value of all data registers
//  CNT_W      stall counter width
// Ports
//  clk_i        in   1      clock
//  rst_ni       in   1      synchronous active-low reset
//  flush_i      in   1      synchronous flush
//  valid_i      in   1      upstream valid
//  ready_o      out  1      stage accepts this cycle
//  data_i       in   WIDTH  upstream payload
//  valid_o      out  1      downstream valid
//  ready_i      in   1      downstream accepts this cycle
//  data_o       out  WIDTH  main register
//  stall_cnt_o  out  CNT_W  cycles with valid_o & ~ready_i, saturating
// ---------------------------------------------------------------------------
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned      WIDTH     = 32,
   parameter int unsigned      SKID      = 0,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
   parameter int unsigned      CNT_W     = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] data_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] data_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic             valid_s;
   logic             ready_s;
   logic [WIDTH-1:0] data_s;
   logic [CNT_W-1:0] stall_cnt_r;

   if (SKID != 0) begin : g_skid

      pipe_skid_buf #(
         .WIDTH     (WIDTH),
         .RESET_VAL (RESET_VAL)
      ) u_skid (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .flush_i (flush_i),
         .valid_i (valid_i),
         .ready_o (ready_s),
         .data_i  (data_i),
         .valid_o (valid_s),
         .ready_i (ready_i),
         .data_o  (data_s)
      );

   end else begin : g_reg

      logic             valid_r;
      logic [WIDTH-1:0] main_r;
      logic             in_s;
      logic             out_s;

      // An empty register or a draining one can take a new payload.
      assign ready_s = ready_i | ~valid_r;
      assign in_s    = valid_i & ready_s;
      assign out_s   = valid_r & ready_i;

      // Single payload register; flush only clears valid.
      always_ff @(posedge clk_i) begin
         if (!rst_ni) begin
            valid_r <= 1'b0;
            main_r  <= RESET_VAL;
         end else if (flush_i) begin
            valid_r <= 1'b0;
         end else if (in_s) begin
            valid_r <= 1'b1;
            main_r  <= data_i;
         end else if (out_s) begin
            valid_r <= 1'b0;
         end else begin
            valid_r <= valid_r;
         end
      end

      assign valid_s = valid_r;
      assign data_s  = main_r;

   end

   // Stall cycles for performance analysis; only reset clears it.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         stall_cnt_r <= {CNT_W{1'b0}};
      end else if (valid_s && !ready_i && !flush_i && (stall_cnt_r != CNT_MAX)) begin
         stall_cnt_r <= stall_cnt_r + CNT_W'(1'b1);
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign ready_o     = ready_s;
   assign valid_o     = valid_s;
   assign data_o      = data_s;
   assign stall_cnt_o = stall_cnt_r;

   pipe_stage_reg_chk #(
      .WIDTH (WIDTH)
   ) u_chk (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .valid_o (valid_s),
      .ready_i (ready_i),
      .data_o  (data_s)
   );

endmodule
